traffic_sequencer: RTL and testbench
====================================

TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 SHALL have parameter CORE_COUNT, default 16: number of mesh cores/loaders.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 5: AXI ID width per loader.
REQ-003 SHALL have parameter PMU_REG_COUNT, default 8 (range 1..32): PMU registers read per core.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock; arstn_i input 1, asynchronous active-low reset.
REQ-005 SHALL have cmd_valid_i input 1 and cmd_ready_o output 1: command handshake.
REQ-006 SHALL have cmd_op_i input 2: 0=PUSH, 1=RUN, 2=READ_PMU, 3=NOP.
REQ-007 SHALL have cmd_core_i input $clog2(CORE_COUNT): target core.
REQ-008 SHALL have cmd_id_i input AXI_ID_WIDTH, cmd_write_i input 1, cmd_axlen_i input 8 and cmd_resp_wait_i input 1: transaction descriptor fields.
REQ-009 SHALL have per-core unpacked arrays [CORE_COUNT]: id_o output AXI_ID_WIDTH; write_o output 1; axlen_o output 8; resp_wait_o output 1; fifo_push_o output 1; idle_i input 1; pmu_addr_o output 5; pmu_data_i input 32.
REQ-010 SHALL have start_o output 1: global loader start pulse.
REQ-011 SHALL have rd_valid_o output 1, rd_ready_i input 1, rd_data_o output 32 and rd_last_o output 1: PMU result stream.
REQ-012 SHALL have busy_o output 1: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, PUSH, START, GUARD, WAIT_IDLE, PMU_ADDR, PMU_SAMPLE and PMU_OUT.
REQ-014 SHALL drive cmd_ready_o=1 only in IDLE; a command is accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-015 SHALL, on PUSH accept: latch the descriptor into id_o/write_o/axlen_o/resp_wait_o[cmd_core_i], enter PUSH, and assert fifo_push_o[cmd_core_i] for exactly one cycle (the cycle after accept), with fields already valid; then return to IDLE.
REQ-016 SHALL leave descriptor outputs of non-addressed cores unchanged and hold all descriptor outputs after a push.
REQ-017 SHALL drop a PUSH or READ_PMU whose cmd_core_i >= CORE_COUNT (non-power-of-2 case): accept it, create no push and no readout, remain in IDLE.
REQ-018 SHALL, on RUN accept: assert start_o for exactly one cycle (START), spend one cycle in GUARD ignoring idle_i, then remain in WAIT_IDLE until all idle_i are high, then return to IDLE.
REQ-019 SHALL accept NOP in one cycle with no output effect.
REQ-020 SHALL, on READ_PMU accept: latch the core, set register index r=0, and enter PMU_ADDR.
REQ-021 SHALL, in PMU_ADDR: drive pmu_addr_o[core]=r and go to PMU_SAMPLE; pmu_data_i is valid one cycle after the address is driven.
REQ-022 SHALL, in PMU_SAMPLE: register pmu_data_i[core] into rd_data_o, set rd_valid_o=1 and rd_last_o=(r==PMU_REG_COUNT-1), and go to PMU_OUT.
REQ-023 SHALL, in PMU_OUT: hold rd_data_o, rd_valid_o and rd_last_o stable until rd_ready_i; on the handshake, drop rd_valid_o and either increment r and return to PMU_ADDR, or go to IDLE if last.
REQ-024 SHALL drive pmu_addr_o of non-addressed cores to 0.
REQ-025 SHALL change no mesh-side output and accept no command while busy_o=1.

Reset
REQ-026 SHALL, while arstn_i=0: force state=IDLE; all fifo_push_o, start_o, rd_valid_o and rd_last_o=0; busy_o=0; id_o, write_o, axlen_o, resp_wait_o, pmu_addr_o and rd_data_o=0; cmd_ready_o=1 from the first clock edge after reset release.
REQ-027 SHALL abort any in-progress RUN or readout on reset assertion mid-operation, with no residual pulse after release.

Verification
REQ-028 SHALL be verified with: PUSH core=3, id=5, write=1, axlen=7, resp_wait=0 -> next cycle fifo_push_o[3]=1 for 1 cycle with id_o[3]=5, axlen_o[3]=7; all other fifo_push_o=0.
REQ-029 SHALL be verified with: RUN, idle_i all 1 throughout -> start_o one cycle; busy_o high at least 3 cycles (START, GUARD, WAIT_IDLE); returns to IDLE.
REQ-030 SHALL be verified with: RUN, idle_i[2]=0 for 50 cycles after start -> cmd_ready_o=0 until the cycle after idle_i[2] rises; second command held off.
REQ-031 SHALL be verified with: READ_PMU core=1, PMU_REG_COUNT=8, pmu_data_i[1]=0x100+addr, rd_ready_i random -> 8 words 0x100..0x107 in order; rd_last_o only on 0x107; data stable while stalled.
REQ-032 SHALL be verified with: arstn_i asserted during PMU_OUT at word 3 -> rd_valid_o=0 immediately; after release cmd_ready_o=1 and no stale word is emitted.
REQ-033 SHALL be verified with: back-to-back PUSH core=0 then core=15 with cmd_valid_i held -> two single-cycle pushes separated by one IDLE cycle, each with its own fields.

Source files
------------

// File: rtl/traffic_sequencer.sv
// Command sequencer for mesh traffic loaders: per-core descriptor pushes, a
// global run with idle wait, and PMU register readout over a ready/valid stream.
module traffic_sequencer #(
    parameter int CORE_COUNT    = 16,
    parameter int AXI_ID_WIDTH  = 5,
    parameter int PMU_REG_COUNT = 8
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,

    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_op_i,
    input  logic [$clog2(CORE_COUNT)-1:0] cmd_core_i,
    input  logic [AXI_ID_WIDTH-1:0]       cmd_id_i,
    input  logic                          cmd_write_i,
    input  logic [7:0]                    cmd_axlen_i,
    input  logic                          cmd_resp_wait_i,

    output logic [AXI_ID_WIDTH-1:0]       id_o        [CORE_COUNT],
    output logic                          write_o     [CORE_COUNT],
    output logic [7:0]                    axlen_o     [CORE_COUNT],
    output logic                          resp_wait_o [CORE_COUNT],
    output logic                          fifo_push_o [CORE_COUNT],
    input  logic                          idle_i      [CORE_COUNT],
    output logic [4:0]                    pmu_addr_o  [CORE_COUNT],
    input  logic [31:0]                   pmu_data_i  [CORE_COUNT],

    output logic                          start_o,

    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [31:0]                   rd_data_o,
    output logic                          rd_last_o,

    output logic                          busy_o
);

    localparam int CORE_W = $clog2(CORE_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        START,
        GUARD,
        WAIT_IDLE,
        PMU_ADDR,
        PMU_SAMPLE,
        PMU_OUT
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH     = 2'd0,
        OP_RUN      = 2'd1,
        OP_READ_PMU = 2'd2,
        OP_NOP      = 2'd3
    } op_t;

    state_t            state_q;
    state_t            state_d;
    op_t               op;
    logic              ready_q;
    logic              accept;
    logic              core_ok;
    logic              all_idle;
    logic              last_reg;
    logic              pmu_active;
    logic [CORE_W-1:0] core_q;
    logic [4:0]        reg_q;
    logic [31:0]       pmu_sel;

    assign op          = op_t'(cmd_op_i);
    assign cmd_ready_o = ready_q && (state_q == IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign core_ok     = 32'(cmd_core_i) < 32'(CORE_COUNT);
    assign last_reg    = (reg_q == 5'(PMU_REG_COUNT - 1));
    assign pmu_active  = (state_q == PMU_ADDR) || (state_q == PMU_SAMPLE) || (state_q == PMU_OUT);
    assign busy_o      = (state_q != IDLE);
    assign start_o     = (state_q == START);

    // Held low through reset so no command is taken before the first clean edge.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        all_idle = 1'b1;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            all_idle = all_idle && idle_i[i];
        end
    end

    always_comb begin
        pmu_sel = '0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            if (core_q == CORE_W'(i)) begin
                pmu_sel = pmu_data_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_PUSH:     if (core_ok) state_d = PUSH;
                        OP_RUN:      state_d = START;
                        OP_READ_PMU: if (core_ok) state_d = PMU_ADDR;
                        default:     state_d = IDLE;
                    endcase
                end
            end
            PUSH:       state_d = IDLE;
            START:      state_d = GUARD;
            GUARD:      state_d = WAIT_IDLE;
            WAIT_IDLE:  if (all_idle) state_d = IDLE;
            PMU_ADDR:   state_d = PMU_SAMPLE;
            PMU_SAMPLE: state_d = PMU_OUT;
            PMU_OUT:    if (rd_ready_i) state_d = last_reg ? IDLE : PMU_ADDR;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            core_q     <= '0;
            reg_q      <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
        end else begin
            if (accept && core_ok && ((op == OP_PUSH) || (op == OP_READ_PMU))) begin
                core_q <= cmd_core_i;
            end
            if (accept && (op == OP_READ_PMU)) begin
                reg_q <= '0;
            end
            case (state_q)
                PMU_SAMPLE: begin
                    rd_data_o  <= pmu_sel;
                    rd_valid_o <= 1'b1;
                    rd_last_o  <= last_reg;
                end
                PMU_OUT: begin
                    if (rd_ready_i) begin
                        rd_valid_o <= 1'b0;
                        rd_last_o  <= 1'b0;
                        if (!last_reg) begin
                            reg_q <= reg_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-core descriptor storage; the push strobe decodes from the PUSH state
    // so the fields are already registered when it fires.
    for (genvar g = 0; g < CORE_COUNT; g++) begin : g_core
        logic                    sel_push;
        logic [AXI_ID_WIDTH-1:0] id_q;
        logic                    write_q;
        logic [7:0]              axlen_q;
        logic                    resp_wait_q;

        assign sel_push = accept && (op == OP_PUSH) && (cmd_core_i == CORE_W'(g));

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                id_q        <= '0;
                write_q     <= 1'b0;
                axlen_q     <= '0;
                resp_wait_q <= 1'b0;
            end else if (sel_push) begin
                id_q        <= cmd_id_i;
                write_q     <= cmd_write_i;
                axlen_q     <= cmd_axlen_i;
                resp_wait_q <= cmd_resp_wait_i;
            end
        end

        assign id_o[g]        = id_q;
        assign write_o[g]     = write_q;
        assign axlen_o[g]     = axlen_q;
        assign resp_wait_o[g] = resp_wait_q;
        assign fifo_push_o[g] = (state_q == PUSH) && (core_q == CORE_W'(g));
        assign pmu_addr_o[g]  = (pmu_active && (core_q == CORE_W'(g))) ? reg_q : '0;
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed and randomized bench for traffic_sequencer with a behavioural
// descriptor/PMU model and immediate-assertion checks.
module tb_traffic_sequencer;

    localparam int NC   = 16;
    localparam int IDW  = 5;
    localparam int NREG = 8;

    localparam logic [1:0] C_PUSH = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_READ = 2'd2;
    localparam logic [1:0] C_NOP  = 2'd3;

    logic           clk = 1'b0;
    logic           arstn;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [3:0]     cmd_core;
    logic [IDW-1:0] cmd_id;
    logic           cmd_write;
    logic [7:0]     cmd_axlen;
    logic           cmd_resp_wait;
    logic [IDW-1:0] id        [NC];
    logic           wr        [NC];
    logic [7:0]     axlen     [NC];
    logic           resp_wait [NC];
    logic           fifo_push [NC];
    logic           idle      [NC];
    logic [4:0]     pmu_addr  [NC];
    logic [31:0]    pmu_data  [NC];
    logic           start;
    logic           rd_valid;
    logic           rd_ready;
    logic [31:0]    rd_data;
    logic           rd_last;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int n;
    int stale;

    logic [IDW-1:0] m_id  [NC];
    logic           m_wr  [NC];
    logic [7:0]     m_len [NC];
    logic           m_rw  [NC];

    traffic_sequencer #(
        .CORE_COUNT   (NC),
        .AXI_ID_WIDTH (IDW),
        .PMU_REG_COUNT(NREG)
    ) dut (
        .clk_i          (clk),
        .arstn_i        (arstn),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_core_i     (cmd_core),
        .cmd_id_i       (cmd_id),
        .cmd_write_i    (cmd_write),
        .cmd_axlen_i    (cmd_axlen),
        .cmd_resp_wait_i(cmd_resp_wait),
        .id_o           (id),
        .write_o        (wr),
        .axlen_o        (axlen),
        .resp_wait_o    (resp_wait),
        .fifo_push_o    (fifo_push),
        .idle_i         (idle),
        .pmu_addr_o     (pmu_addr),
        .pmu_data_i     (pmu_data),
        .start_o        (start),
        .rd_valid_o     (rd_valid),
        .rd_ready_i     (rd_ready),
        .rd_data_o      (rd_data),
        .rd_last_o      (rd_last),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // PMU register file model: one-cycle read latency from the address.
    function automatic logic [31:0] ref_pmu(input int core, input logic [4:0] a);
        if (core == 1) return 32'h100 + {27'd0, a};
        return 32'hA500_0000 | (32'(core) << 8) | {27'd0, a};
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            pmu_data[i] <= ref_pmu(i, pmu_addr[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_id[i] = '0; m_wr[i] = 1'b0; m_len[i] = '0; m_rw[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] push_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NC; i++) v[i] = fifo_push[i];
        return v;
    endfunction

    function automatic logic [31:0] desc_mismatch();
        logic [31:0] v = '0;
        for (int i = 0; i < NC; i++)
            if ({id[i], wr[i], axlen[i], resp_wait[i]} !== {m_id[i], m_wr[i], m_len[i], m_rw[i]})
                v[i] = 1'b1;
        return v;
    endfunction

    function automatic int addr_nonzero(input int skip);
        int c = 0;
        for (int i = 0; i < NC; i++)
            if (i != skip && pmu_addr[i] !== 5'd0) c++;
        return c;
    endfunction

    task automatic set_fields(input int core, input logic [IDW-1:0] i_id, input logic w,
                              input logic [7:0] len, input logic rw);
        cmd_op = C_PUSH; cmd_core = 4'(core); cmd_id = i_id;
        cmd_write = w; cmd_axlen = len; cmd_resp_wait = rw;
    endtask

    task automatic model_push(input int core);
        m_id[core] = cmd_id; m_wr[core] = cmd_write; m_len[core] = cmd_axlen; m_rw[core] = cmd_resp_wait;
    endtask

    task automatic do_push(input int core, input logic [IDW-1:0] i_id, input logic w,
                           input logic [7:0] len, input logic rw);
        set_fields(core, i_id, w, len, rw);
        cmd_valid = 1'b1;
        check("push_ready", cmd_ready, 1);
        tick();
        model_push(core);
        cmd_valid = 1'b0;
        check("push_strobe", push_vec(), 32'(1) << core);
        check("push_fields", desc_mismatch(), 0);
        check("push_busy_ready", {busy, cmd_ready}, 2'b10);
        tick();
        check("push_one_cycle", push_vec(), 0);
        check("push_hold", desc_mismatch(), 0);
        check("push_back_idle", cmd_ready, 1);
    endtask

    task automatic do_nop();
        cmd_op = C_NOP; cmd_valid = 1'b1;
        check("nop_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("nop_effect", {busy, start, rd_valid, cmd_ready}, 4'b0001);
        check("nop_push", push_vec(), 0);
        check("nop_desc", desc_mismatch(), 0);
    endtask

    // Busy span after accept: START, GUARD, then WAIT_IDLE until the first
    // cycle in which every idle input is seen high.
    task automatic do_run(input int k, input int d, input bit hold);
        int busy_n = 0, start_n = 0, start_at = 0, leak = 0;
        int exp_busy = (d + 1 > 3) ? d + 1 : 3;
        idle[k] = 1'b0;
        cmd_op = C_RUN; cmd_valid = 1'b1;
        check("run_ready", cmd_ready, 1);
        tick();
        if (hold) set_fields(7, 5'(13 + d), 1'b1, 8'(d), 1'b1);
        else cmd_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > d) idle[k] = 1'b1;
            if (busy !== 1'b1) break;
            busy_n++;
            if (start === 1'b1) begin start_n++; start_at = c; end
            if (cmd_ready !== 1'b0 || push_vec() != 0) leak++;
            tick();
        end
        idle[k] = 1'b1;
        check("run_busy_cycles", busy_n, exp_busy);
        check("run_start_count", start_n, 1);
        check("run_start_first", start_at, 1);
        check("run_no_accept_busy", leak, 0);
        check("run_ready_after", cmd_ready, 1);
        if (hold) begin
            tick();
            model_push(7);
            cmd_valid = 1'b0;
            check("run_held_push", push_vec(), 32'(1) << 7);
            check("run_held_fields", desc_mismatch(), 0);
            tick();
            check("run_held_done", push_vec(), 0);
        end
    endtask

    task automatic do_read(input int core);
        logic [31:0] words [NREG];
        logic [7:0]  lastmask = '0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        int          cnt = 0, unstable = 0, addr_bad = 0;
        for (int k = 0; k < NREG; k++) words[k] = '0;
        cmd_op = C_READ; cmd_core = 4'(core); cmd_valid = 1'b1;
        check("read_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; cmd_op = C_NOP;
        for (int c = 0; c < 400 && cnt < NREG; c++) begin
            rd_ready = ($urandom_range(0, 2) != 0);
            if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last))
                unstable++;
            addr_bad += addr_nonzero(core);
            if (rd_valid === 1'b1 && rd_ready) begin
                words[cnt] = rd_data;
                lastmask[cnt] = rd_last;
                cnt++;
            end
            prev_stall = (rd_valid === 1'b1) && !rd_ready;
            prev_data = rd_data;
            prev_last = rd_last;
            tick();
        end
        rd_ready = 1'b0;
        check("read_word_count", cnt, NREG);
        for (int k = 0; k < NREG; k++) check($sformatf("read_word%0d", k), words[k], ref_pmu(core, 5'(k)));
        check("read_last_mask", lastmask, 8'h80);
        check("read_stall_stable", unstable, 0);
        check("read_other_addr", addr_bad, 0);
        check("read_done", {busy, rd_valid, cmd_ready}, 3'b001);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0; cmd_valid = 1'b0; cmd_op = C_NOP; cmd_core = '0; cmd_id = '0;
        cmd_write = 1'b0; cmd_axlen = '0; cmd_resp_wait = 1'b0; rd_ready = 1'b0;
        for (int i = 0; i < NC; i++) idle[i] = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, start, rd_valid, rd_last}, 4'b0000);
        check("rst_push", push_vec(), 0);
        check("rst_desc", desc_mismatch(), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_pmu_addr", addr_nonzero(-1), 0);
        arstn = 1'b1;
        tick();
        check("rst_ready_after", cmd_ready, 1);

        do_push(3, 5'd5, 1'b1, 8'd7, 1'b0);

        // Back-to-back pushes with valid held: one IDLE cycle between them.
        set_fields(0, 5'd9, 1'b0, 8'd33, 1'b1);
        cmd_valid = 1'b1;
        tick();
        model_push(0);
        check("b2b_push0", push_vec(), 32'(1));
        check("b2b_fields0", desc_mismatch(), 0);
        set_fields(15, 5'd22, 1'b1, 8'd200, 1'b0);
        tick();
        check("b2b_gap", {cmd_ready, 1'b0} | 2'(push_vec() != 0), 2'b10);
        tick();
        model_push(15);
        cmd_valid = 1'b0;
        check("b2b_push15", push_vec(), 32'(1) << 15);
        check("b2b_fields15", desc_mismatch(), 0);
        tick();
        check("b2b_end", push_vec(), 0);

        do_run(0, 0, 1'b0);
        do_run(2, 50, 1'b1);
        do_read(1);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 4))
                0, 1: do_push($urandom_range(0, NC - 1), 5'($urandom), 1'($urandom),
                              8'($urandom), 1'($urandom));
                2: do_nop();
                3: do_read($urandom_range(0, NC - 1));
                default: do_run($urandom_range(0, NC - 1), $urandom_range(0, 10), 1'b0);
            endcase
        end

        // Reset while word 3 of a readout is being presented.
        cmd_op = C_READ; cmd_core = 4'd1; cmd_valid = 1'b1;
        check("abort_rd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; cmd_op = C_NOP;
        n = 0;
        for (int c = 0; c < 100 && n < 3; c++) begin
            rd_ready = 1'b1;
            if (rd_valid === 1'b1) n++;
            tick();
        end
        rd_ready = 1'b0;
        for (int c = 0; c < 20 && rd_valid !== 1'b1; c++) tick();
        check("abort_word3", rd_data, ref_pmu(1, 5'd3));
        #2;
        arstn = 1'b0;
        #1;
        model_reset();
        check("abort_rd_clear", {rd_valid, rd_last, busy}, 3'b000);
        check("abort_rd_data", rd_data, 0);
        check("abort_desc", desc_mismatch(), 0);
        tick();
        arstn = 1'b1;
        tick();
        check("abort_ready_after", cmd_ready, 1);
        rd_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_valid !== 1'b0 || start !== 1'b0 || busy !== 1'b0 || push_vec() != 0) stale++;
            tick();
        end
        rd_ready = 1'b0;
        check("abort_no_stale", stale, 0);

        // Reset while waiting for idle during a run.
        idle[0] = 1'b0;
        cmd_op = C_RUN; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_op = C_NOP;
        repeat (3) tick();
        check("run_abort_pre", busy, 1);
        arstn = 1'b0;
        #1;
        check("run_abort_clear", {busy, start}, 2'b00);
        tick();
        idle[0] = 1'b1;
        arstn = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (start !== 1'b0 || busy !== 1'b0) stale++;
        end
        check("run_abort_no_pulse", stale, 0);
        check("run_abort_ready", cmd_ready, 1);

        do_push(9, 5'd17, 1'b1, 8'd255, 1'b1);
        do_read(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
